exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Multi-cycle sequencer that drives the NPC datapath one instruction at a time: fetch, execute, optional memory access, then write-back/commit.
- Consumes the decoder's per-instruction controls (reg_wen, mem_ren, mem_wen, ebreak).
- Produces the register write strobes (IR, MDR, regfile, PC) and the valid/ready request handshakes toward the instruction-fetch and load/store buses.
- Sits between the decoder and the memory bus adapters; owns the halt and bus-error status.

Parameters:
- TIMEOUT_CYCLES, 255: number of wait cycles without a response before entering ERR. 0 disables the timeout. Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid  out  1  fetch request valid
- ifu_req_ready  in  1  fetch request accepted
- ifu_resp_valid  in  1  instruction word available this cycle
- ir_wen  out  1  latch instruction register
- dec_reg_wen  in  1  decoded regfile write enable
- dec_mem_ren  in  1  decoded load
- dec_mem_wen  in  1  decoded store
- dec_ebreak  in  1  decoded ebreak
- lsu_req_valid  out  1  data request valid
- lsu_req_wen  out  1  data request is a write
- lsu_req_ready  in  1  data request accepted
- lsu_resp_valid  in  1  load data valid / store done
- mdr_wen  out  1  latch memory data register
- rf_wen  out  1  regfile write strobe
- pc_wen  out  1  PC update strobe
- commit  out  1  instruction retired pulse
- halted  out  1  ebreak reached (sticky)
- bus_err  out  1  bus timeout (sticky)
- state  out  4  current state, for debug/trace

Behaviour:
- Reset state IDLE. While rst is high, every output is 0 and state=0.

State encoding:
- IDLE=0, IF_REQ=1, IF_WAIT=2, EXEC=3, MEM_REQ=4, MEM_WAIT=5, WB=6, HALT=7, ERR=8.

Transitions (one per clk rising edge):
- IDLE -> IF_REQ, unconditionally.
- IF_REQ: ifu_req_valid=1. Goes to IF_WAIT when ifu_req_ready=1, else stays.
- IF_WAIT: on ifu_resp_valid, pulse ir_wen and go to EXEC.
- EXEC: decoder inputs are sampled here only, and must be stable while in EXEC.
  - dec_ebreak -> HALT; this has priority over load/store.
  - else dec_mem_ren|dec_mem_wen -> MEM_REQ.
  - else -> WB.
- MEM_REQ: lsu_req_valid=1 and lsu_req_wen=dec_mem_wen. Goes to MEM_WAIT on lsu_req_ready.
- MEM_WAIT: on lsu_resp_valid, go to WB; mdr_wen pulses only if dec_mem_ren.
- WB: pc_wen=1, commit=1, rf_wen=dec_reg_wen, all for exactly one cycle. Then -> IF_REQ.
- HALT: halted=1. Absorbing until rst. The ebreak does not commit, and pc_wen/rf_wen stay 0.
- ERR: bus_err=1. Absorbing until rst.

Handshake rules:
- Request valid is held high until accepted. Valid never drops without ready.
- Responses are honoured only in the WAIT states. A resp_valid arriving in a REQ state or any other state is ignored; the bus guarantees at least one cycle of latency.

Outputs and latency:
- All outputs are Moore, decoded from state and latched decoder inputs. There are no combinational paths from *_ready or *_resp_valid to outputs, except the ir_wen and mdr_wen pulses, which are gated by resp_valid in the WAIT states.
- Zero-wait bus latency: ALU/branch/jump instruction = 4 cycles (IF_REQ, IF_WAIT, EXEC, WB); load/store = 6 cycles.

Timeout:
- The counter clears on entry to IF_WAIT or MEM_WAIT and increments on each WAIT cycle without a response.
- If the counter equals TIMEOUT_CYCLES-1 and there is no response, the next state is ERR. ERR is therefore entered after TIMEOUT_CYCLES response-less wait cycles.
- If the response arrives in the same cycle the limit is hit, the response wins and the normal transition occurs.
- The timeout does not apply in REQ states.

Other boundaries:
- Async rst asserted mid-instruction: immediately returns to IDLE with all strobes 0. There is no partial commit.
- Clearing halted/bus_err requires rst.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined, adds ports:
  - perf_cycle  out  64: increments every cycle the state is not IDLE, HALT or ERR.
  - perf_instret  out  64: increments on each commit.
- Both counters reset to 0 and wrap modulo 2^64.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ALU instruction, ifu ready/resp immediate, dec_reg_wen=1 -> state sequence 0,1,2,3,6,1; commit, pc_wen and rf_wen each high exactly one cycle (cycle 5 after reset release).
- Load, dec_mem_ren=1, lsu_req_ready delayed 3 cycles and resp 2 cycles later -> lsu_req_valid held 4 cycles; mdr_wen pulses once; rf_wen in WB; 11 cycles fetch-to-commit.
- Store, dec_mem_wen=1, dec_reg_wen=0 -> lsu_req_wen=1 during MEM_REQ; mdr_wen=0; rf_wen=0; commit=1.
- dec_ebreak=1 together with dec_mem_ren=1 -> EXEC->HALT; no lsu_req_valid; no commit; halted stays 1 for 100 cycles.
- TIMEOUT_CYCLES=4, ifu_resp_valid never asserted -> ERR after 4 IF_WAIT cycles; bus_err=1. Repeat with resp on the 4th wait cycle -> EXEC, bus_err=0.
- rst pulsed during MEM_WAIT -> all outputs 0 asynchronously. With SEQ_PERF_CNT_EN, after 3 ALU instructions from reset: perf_instret=3, perf_cycle=12.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Sequencer-facing bundle: fetch/load-store request handshakes, decoder controls, datapath strobes and status.
// The master side is the sequencer. The slave side is the decoder, bus adapters and datapath.
interface exec_sequencer_if;
    logic       ifu_req_valid;
    logic       ifu_req_ready;
    logic       ifu_resp_valid;
    logic       ir_wen;
    logic       dec_reg_wen;
    logic       dec_mem_ren;
    logic       dec_mem_wen;
    logic       dec_ebreak;
    logic       lsu_req_valid;
    logic       lsu_req_wen;
    logic       lsu_req_ready;
    logic       lsu_resp_valid;
    logic       mdr_wen;
    logic       rf_wen;
    logic       pc_wen;
    logic       commit;
    logic       halted;
    logic       bus_err;
    logic [3:0] state;

    modport master (
        output ifu_req_valid, ir_wen, lsu_req_valid, lsu_req_wen, mdr_wen,
               rf_wen, pc_wen, commit, halted, bus_err, state,
        input  ifu_req_ready, ifu_resp_valid, dec_reg_wen, dec_mem_ren,
               dec_mem_wen, dec_ebreak, lsu_req_ready, lsu_resp_valid
    );

    modport slave (
        input  ifu_req_valid, ir_wen, lsu_req_valid, lsu_req_wen, mdr_wen,
               rf_wen, pc_wen, commit, halted, bus_err, state,
        output ifu_req_ready, ifu_resp_valid, dec_reg_wen, dec_mem_ren,
               dec_mem_wen, dec_ebreak, lsu_req_ready, lsu_resp_valid
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/exec/mem/write-back sequencer: 4 cycles ALU, 6 cycles load/store at zero wait; requests held until ready.
// WAIT states time out to ERR after TIMEOUT_CYCLES silent cycles; SEQ_PERF_CNT_EN adds cycle/instret counters.
module exec_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    exec_sequencer_if.master bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [63:0]      perf_cycle,
    output logic [63:0]      perf_instret
`endif
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_IF_REQ   = 4'd1,
        S_IF_WAIT  = 4'd2,
        S_EXEC     = 4'd3,
        S_MEM_REQ  = 4'd4,
        S_MEM_WAIT = 4'd5,
        S_WB       = 4'd6,
        S_HALT     = 4'd7,
        S_ERR      = 4'd8
    } state_t;

    state_t        st;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          tmo_hit;

    logic          reg_wen_q;
    logic          mem_ren_q;
    logic          mem_wen_q;
    logic          reg_wen_n;
    logic          mem_wen_n;

    logic          ifu_req_valid_q;
    logic          lsu_req_valid_q;
    logic          lsu_req_wen_q;
    logic          rf_wen_q;
    logic          wb_q;
    logic          halted_q;
    logic          bus_err_q;

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);

    // Decoder controls are live only in EXEC; elsewhere the latched copy is authoritative.
    assign reg_wen_n = (st == S_EXEC) ? bus.dec_reg_wen : reg_wen_q;
    assign mem_wen_n = (st == S_EXEC) ? bus.dec_mem_wen : mem_wen_q;

    always_comb begin
        nxt     = st;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (st)
            S_IDLE:    nxt = S_IF_REQ;
            S_IF_REQ: begin
                if (bus.ifu_req_ready) begin
                    nxt     = S_IF_WAIT;
                    cnt_clr = 1'b1;
                end
            end
            S_IF_WAIT: begin
                if (bus.ifu_resp_valid) nxt = S_EXEC;
                else if (tmo_hit)       nxt = S_ERR;
                else                    cnt_inc = 1'b1;
            end
            S_EXEC: begin
                if (bus.dec_ebreak)                         nxt = S_HALT;
                else if (bus.dec_mem_ren | bus.dec_mem_wen) nxt = S_MEM_REQ;
                else                                        nxt = S_WB;
            end
            S_MEM_REQ: begin
                if (bus.lsu_req_ready) begin
                    nxt     = S_MEM_WAIT;
                    cnt_clr = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (bus.lsu_resp_valid) nxt = S_WB;
                else if (tmo_hit)       nxt = S_ERR;
                else                    cnt_inc = 1'b1;
            end
            S_WB:      nxt = S_IF_REQ;
            S_HALT:    nxt = S_HALT;
            S_ERR:     nxt = S_ERR;
            default:   nxt = S_IDLE;
        endcase
    end

    // Moore strobes are registered from the next state so they line up with st.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st              <= S_IDLE;
            cnt             <= '0;
            reg_wen_q       <= 1'b0;
            mem_ren_q       <= 1'b0;
            mem_wen_q       <= 1'b0;
            ifu_req_valid_q <= 1'b0;
            lsu_req_valid_q <= 1'b0;
            lsu_req_wen_q   <= 1'b0;
            rf_wen_q        <= 1'b0;
            wb_q            <= 1'b0;
            halted_q        <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            st <= nxt;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (st == S_EXEC) begin
                reg_wen_q <= bus.dec_reg_wen;
                mem_ren_q <= bus.dec_mem_ren;
                mem_wen_q <= bus.dec_mem_wen;
            end
            ifu_req_valid_q <= (nxt == S_IF_REQ);
            lsu_req_valid_q <= (nxt == S_MEM_REQ);
            lsu_req_wen_q   <= (nxt == S_MEM_REQ) && mem_wen_n;
            rf_wen_q        <= (nxt == S_WB) && reg_wen_n;
            wb_q            <= (nxt == S_WB);
            halted_q        <= (nxt == S_HALT);
            bus_err_q       <= (nxt == S_ERR);
        end
    end

    assign bus.ifu_req_valid = ifu_req_valid_q;
    assign bus.lsu_req_valid = lsu_req_valid_q;
    assign bus.lsu_req_wen   = lsu_req_wen_q;
    assign bus.rf_wen        = rf_wen_q;
    assign bus.pc_wen        = wb_q;
    assign bus.commit        = wb_q;
    assign bus.halted        = halted_q;
    assign bus.bus_err       = bus_err_q;
    assign bus.state         = st;

    // Latch pulses are the only outputs that see a response combinationally.
    assign bus.ir_wen  = (st == S_IF_WAIT) && bus.ifu_resp_valid;
    assign bus.mdr_wen = (st == S_MEM_WAIT) && bus.lsu_resp_valid && mem_ren_q;

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycle   <= 64'd0;
            perf_instret <= 64'd0;
        end else begin
            if (st != S_IDLE && st != S_HALT && st != S_ERR) perf_cycle <= perf_cycle + 64'd1;
            if (wb_q) perf_instret <= perf_instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboarded bench for exec_sequencer: per-cycle expected state/strobes are queued as stimulus is applied.
module tb_exec_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exec_sequencer_if bus();

`ifdef SEQ_PERF_CNT_EN
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;
`endif

    exec_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycle   (perf_cycle),
        .perf_instret (perf_instret)
`endif
    );

    // Expected strobe flags (low 10 bits of an observation; state sits above).
    localparam logic [9:0] NONE = 10'h000, IFV = 10'h200, IRW = 10'h100, LSV = 10'h080,
                           LSW  = 10'h040, MDR = 10'h020, RFW = 10'h010, PCW = 10'h008,
                           CMT  = 10'h004, HLT = 10'h002, BER = 10'h001;
    localparam logic [7:0] IRDY = 8'h80, IRSP = 8'h40, LRDY = 8'h20, LRSP = 8'h10,
                           RW   = 8'h08, MR   = 8'h04, MW   = 8'h02, EB   = 8'h01;

    logic [13:0] obs;
    assign obs = {bus.state, bus.ifu_req_valid, bus.ir_wen, bus.lsu_req_valid, bus.lsu_req_wen,
                  bus.mdr_wen, bus.rf_wen, bus.pc_wen, bus.commit, bus.halted, bus.bus_err};

    logic [13:0] sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic drive_in(input logic [7:0] in);
        bus.ifu_req_ready  = in[7];
        bus.ifu_resp_valid = in[6];
        bus.lsu_req_ready  = in[5];
        bus.lsu_resp_valid = in[4];
        bus.dec_reg_wen    = in[3];
        bus.dec_mem_ren    = in[2];
        bus.dec_mem_wen    = in[1];
        bus.dec_ebreak     = in[0];
    endtask

    // Drive one cycle's inputs, queue its expectation, move to the sampling point.
    task automatic apply(input logic [7:0] in, input logic [13:0] ex);
        drive_in(in);
        sb.push_back(ex);
        @(negedge clk);
    endtask

    // Leaves the bench at posedge+1 with the DUT in IDLE.
    task automatic do_reset();
        rst = 1'b1;
        drive_in(8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] ex;
        rst = 1'b1;
        drive_in(8'hFF);
        #1;
        sb.push_back(14'h0);
        ex = sb.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL reset_async: got %b want %b", obs, ex);
        end
        repeat (3) begin
            @(negedge clk);
            sb.push_back(14'h0);
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL reset_held: got %b want %b", obs, ex);
            end
`ifdef SEQ_PERF_CNT_EN
            vectors++;
            if (perf_cycle !== 64'd0 || perf_instret !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_perf: got cycle=%0d instret=%0d want 0/0", perf_cycle, perf_instret);
            end
`endif
        end
    endtask

    task automatic test_alu();
        logic [7:0]  in_t[6];
        logic [13:0] ex_t[6];
        logic [13:0] ex;
        in_t = '{RW|IRDY|IRSP, RW|IRDY|IRSP, RW|IRDY|IRSP, RW|IRDY|IRSP, RW|IRDY|IRSP, RW|IRDY|IRSP};
        ex_t = '{{4'd0, NONE}, {4'd1, IFV}, {4'd2, IRW}, {4'd3, NONE}, {4'd6, PCW|RFW|CMT}, {4'd1, IFV}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(in_t[i], ex_t[i]);
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL alu[%0d]: got state=%0d strobes=%b want state=%0d strobes=%b",
                         i, obs[13:10], obs[9:0], ex[13:10], ex[9:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        logic [7:0]  in_t[13];
        logic [13:0] ex_t[13];
        logic [13:0] ex;
        in_t = '{MR|RW, MR|RW|IRDY, MR|RW|IRSP, MR|RW, MR|RW|LRSP, MR|RW, MR|RW, MR|RW|LRDY,
                 MR|RW, MR|RW, MR|RW|LRSP, MR|RW, MR|RW};
        ex_t = '{{4'd0, NONE}, {4'd1, IFV}, {4'd2, IRW}, {4'd3, NONE}, {4'd4, LSV}, {4'd4, LSV},
                 {4'd4, LSV}, {4'd4, LSV}, {4'd5, NONE}, {4'd5, NONE}, {4'd5, MDR},
                 {4'd6, PCW|RFW|CMT}, {4'd1, IFV}};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(in_t[i], ex_t[i]);
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL load[%0d]: got state=%0d strobes=%b want state=%0d strobes=%b",
                         i, obs[13:10], obs[9:0], ex[13:10], ex[9:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        logic [7:0]  in_t[8];
        logic [13:0] ex_t[8];
        logic [13:0] ex;
        in_t = '{MW, MW|IRDY, MW|IRSP, MW, MW|LRDY, MW|LRSP, MW, MW};
        ex_t = '{{4'd0, NONE}, {4'd1, IFV}, {4'd2, IRW}, {4'd3, NONE}, {4'd4, LSV|LSW},
                 {4'd5, NONE}, {4'd6, PCW|CMT}, {4'd1, IFV}};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(in_t[i], ex_t[i]);
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL store[%0d]: got state=%0d strobes=%b want state=%0d strobes=%b",
                         i, obs[13:10], obs[9:0], ex[13:10], ex[9:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ebreak();
        logic [7:0]  in_t[4];
        logic [13:0] ex_t[4];
        logic [13:0] ex;
        in_t = '{EB|MR|RW, EB|MR|RW|IRDY, EB|MR|RW|IRSP, EB|MR|RW};
        ex_t = '{{4'd0, NONE}, {4'd1, IFV}, {4'd2, IRW}, {4'd3, NONE}};
        do_reset();
        for (int i = 0; i < 104; i++) begin
            if (i < 4) apply(in_t[i], ex_t[i]);
            else       apply(8'hFF, {4'd7, HLT});
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL ebreak[%0d]: got state=%0d strobes=%b want state=%0d strobes=%b",
                         i, obs[13:10], obs[9:0], ex[13:10], ex[9:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [7:0]  ina[14];
        logic [13:0] exa[14];
        logic [7:0]  inb[9];
        logic [13:0] exb[9];
        logic [13:0] ex;
        ina = '{RW, RW, RW, RW, RW, RW, RW, RW|IRDY, RW, RW, RW, RW, RW|IRSP|LRSP, 8'hFF};
        exa = '{{4'd0, NONE}, {4'd1, IFV}, {4'd1, IFV}, {4'd1, IFV}, {4'd1, IFV}, {4'd1, IFV},
                {4'd1, IFV}, {4'd1, IFV}, {4'd2, NONE}, {4'd2, NONE}, {4'd2, NONE}, {4'd2, NONE},
                {4'd8, BER}, {4'd8, BER}};
        inb = '{RW, RW|IRDY, RW, RW, RW, RW|IRSP, RW, RW, RW};
        exb = '{{4'd0, NONE}, {4'd1, IFV}, {4'd2, NONE}, {4'd2, NONE}, {4'd2, NONE}, {4'd2, IRW},
                {4'd3, NONE}, {4'd6, PCW|RFW|CMT}, {4'd1, IFV}};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            apply(ina[i], exa[i]);
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL timeout_err[%0d]: got state=%0d strobes=%b want state=%0d strobes=%b",
                         i, obs[13:10], obs[9:0], ex[13:10], ex[9:0]);
            end
            @(posedge clk); #1;
        end
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(inb[i], exb[i]);
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL timeout_edge[%0d]: got state=%0d strobes=%b want state=%0d strobes=%b",
                         i, obs[13:10], obs[9:0], ex[13:10], ex[9:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  in_t[5];
        logic [13:0] ex_t[5];
        logic [13:0] ex;
        in_t = '{MR|RW, MR|RW|IRDY, MR|RW|IRSP, MR|RW, MR|RW|LRDY};
        ex_t = '{{4'd0, NONE}, {4'd1, IFV}, {4'd2, IRW}, {4'd3, NONE}, {4'd4, LSV}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(in_t[i], ex_t[i]);
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL rst_mid[%0d]: got state=%0d strobes=%b want state=%0d strobes=%b",
                         i, obs[13:10], obs[9:0], ex[13:10], ex[9:0]);
            end
            @(posedge clk); #1;
        end
        // In MEM_WAIT with a load response pending; reset lands between clock edges.
        drive_in(MR|RW|LRSP);
        #1;
        sb.push_back({4'd5, MDR});
        ex = sb.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL rst_mid_wait: got %b want %b", obs, ex);
        end
        #1 rst = 1'b1;
        #1;
        sb.push_back(14'h0);
        ex = sb.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %b want %b", obs, ex);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply(RW|IRDY|IRSP, (i == 0) ? {4'd0, NONE} : {4'd1, IFV});
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL rst_mid_restart[%0d]: got %b want %b", i, obs, ex);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] ex;
        logic [13:0] phase[4];
        phase = '{{4'd1, IFV}, {4'd2, IRW}, {4'd3, NONE}, {4'd6, PCW|RFW|CMT}};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            apply(RW|IRDY|IRSP, (i == 0) ? {4'd0, NONE} : phase[(i - 1) % 4]);
            ex = sb.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got state=%0d strobes=%b want state=%0d strobes=%b",
                         i, obs[13:10], obs[9:0], ex[13:10], ex[9:0]);
            end
`ifdef SEQ_PERF_CNT_EN
            if (i == 13) begin
                vectors++;
                if (perf_cycle !== 64'd12 || perf_instret !== 64'd3) begin
                    miscompares++;
                    $display("FAIL b2b_perf: got cycle=%0d instret=%0d want 12/3", perf_cycle, perf_instret);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_ebreak();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
